operand2_handler: RTL and testbench



---
 rtl/datapath_pkg.sv | 20 ++
 rtl/imm_extender.sv | 19 +
 rtl/operand2_handler.sv | 64 ++++++
 tb/tb_operand2_handler.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/datapath_pkg.sv
// Shared datapath constants.
//   DATA_W / IMM_W : datapath and immediate widths
//   SEL_W          : width of the operand-2 select
//   OP2_*          : operand-2 select encodings driven by the control unit
package datapath_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned IMM_W  = 16;
    localparam int unsigned SEL_W  = 3;

    localparam logic [SEL_W-1:0] OP2_PB   = 3'b000;
    localparam logic [SEL_W-1:0] OP2_HI   = 3'b001;
    localparam logic [SEL_W-1:0] OP2_LO   = 3'b010;
    localparam logic [SEL_W-1:0] OP2_PC   = 3'b011;
    localparam logic [SEL_W-1:0] OP2_SEXT = 3'b100;
    localparam logic [SEL_W-1:0] OP2_LUI  = 3'b101;
    localparam logic [SEL_W-1:0] OP2_ZEXT = 3'b110;
    localparam logic [SEL_W-1:0] OP2_ZERO = 3'b111;

endpackage

// File: rtl/imm_extender.sv
// Builds the three 32-bit forms of the instruction immediate.
//   i_imm16 : instruction immediate [15:0]
//   o_sext  : sign-extended immediate
//   o_lui   : immediate in the upper half, lower half zero
//   o_zext  : zero-extended immediate
module imm_extender
    import datapath_pkg::*;
(
    input  logic [IMM_W-1:0]  i_imm16,
    output logic [DATA_W-1:0] o_sext,
    output logic [DATA_W-1:0] o_lui,
    output logic [DATA_W-1:0] o_zext
);

    assign o_sext = {{(DATA_W - IMM_W){i_imm16[IMM_W-1]}}, i_imm16};
    assign o_lui  = {i_imm16, {(DATA_W - IMM_W){1'b0}}};
    assign o_zext = {{(DATA_W - IMM_W){1'b0}}, i_imm16};

endmodule

// File: rtl/operand2_handler.sv
// Registered ALU second-operand selector.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset, clears N
//   en    : capture enable for N
//   PB    : register file port B
//   HI/LO : special registers
//   PC    : program counter
//   imm16 : instruction immediate
//   S     : operand select (OP2_* encodings)
//   N     : selected operand, one cycle after capture
module operand2_handler
    import datapath_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [DATA_W-1:0] PB,
    input  logic [DATA_W-1:0] HI,
    input  logic [DATA_W-1:0] LO,
    input  logic [DATA_W-1:0] PC,
    input  logic [IMM_W-1:0]  imm16,
    input  logic [SEL_W-1:0]  S,
    output logic [DATA_W-1:0] N
);

    logic [DATA_W-1:0] w_sext;
    logic [DATA_W-1:0] w_lui;
    logic [DATA_W-1:0] w_zext;
    logic [DATA_W-1:0] w_sel;
    logic [DATA_W-1:0] r_n;

    imm_extender u_imm_extender (
        .i_imm16 (imm16),
        .o_sext  (w_sext),
        .o_lui   (w_lui),
        .o_zext  (w_zext)
    );

    // Default covers the reserved encoding and any unknown select: drive zero.
    always_comb begin
        w_sel = '0;
        case (S)
            OP2_PB:   w_sel = PB;
            OP2_HI:   w_sel = HI;
            OP2_LO:   w_sel = LO;
            OP2_PC:   w_sel = PC;
            OP2_SEXT: w_sel = w_sext;
            OP2_LUI:  w_sel = w_lui;
            OP2_ZEXT: w_sel = w_zext;
            default:  w_sel = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_n <= '0;
        end else if (en) begin
            r_n <= w_sel;
        end
    end

    assign N = r_n;

endmodule

// File: tb/tb_operand2_handler.sv
// Self-checking bench for operand2_handler: behavioural model compared on
// every falling edge, plus directed literal checks.
module tb_operand2_handler;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [31:0] PB;
    logic [31:0] HI;
    logic [31:0] LO;
    logic [31:0] PC;
    logic [15:0] imm16;
    logic [2:0]  S;
    logic [31:0] N;

    int errors;
    int checks;
    logic        running;
    logic [31:0] m_n;

    operand2_handler dut (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .PB    (PB),
        .HI    (HI),
        .LO    (LO),
        .PC    (PC),
        .imm16 (imm16),
        .S     (S),
        .N     (N)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Operand value from the select rules, using plain arithmetic.
    function automatic logic [31:0] model_sel(input int s, input logic [31:0] pb,
                                              input logic [31:0] hi, input logic [31:0] lo,
                                              input logic [31:0] pc, input logic [15:0] imm);
        int          v;
        logic [31:0] r;
        v = int'(imm);
        r = 32'd0;
        if (s == 0)      r = pb;
        else if (s == 1) r = hi;
        else if (s == 2) r = lo;
        else if (s == 3) r = pc;
        else if (s == 4) begin
            if (v >= 32768) v = v - 65536;
            r = 32'(v);
        end
        else if (s == 5) r = 32'(v) * 32'd65536;
        else if (s == 6) r = 32'(v);
        return r;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m_n <= 32'd0;
        else if (en) m_n <= model_sel(int'(S), PB, HI, LO, PC, imm16);
    end

    always @(negedge clk) begin
        if (running) begin
            checks = checks + 1;
            if (N !== m_n) begin
                errors = errors + 1;
                $display("FAIL model_cmp t=%0t: N=%08h expected=%08h", $time, N, m_n);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] exp);
        checks = checks + 1;
        if (N !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: N=%08h expected=%08h", name, N, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic common();
        PB    = 32'h2235_4678;
        HI    = 32'hABCD_EF01;
        LO    = 32'h7EDC_BA89;
        PC    = 32'hFEDC_BA98;
        imm16 = 16'h6C44;
        en    = 1'b1;
    endtask

    logic [31:0] sweep_exp [8];

    initial begin
        errors  = 0;
        checks  = 0;
        running = 1'b0;
        sweep_exp = '{32'h2235_4678, 32'hABCD_EF01, 32'h7EDC_BA89, 32'hFEDC_BA98,
                      32'h0000_6C44, 32'h6C44_0000, 32'h0000_6C44, 32'h0000_0000};
        common();
        S     = 3'b001;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        check("reset_async", 32'h0);
        running = 1'b1;
        tick();
        check("reset_hold_edge", 32'h0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        tick();
        check("reset_release", 32'hABCD_EF01);

        for (int i = 0; i < 8; i++) begin
            S = 3'(i);
            tick();
            check($sformatf("sweep_s%0d", i), sweep_exp[i]);
        end

        imm16 = 16'hBEEF;
        S = 3'b100; tick(); check("neg_sext", 32'hFFFF_BEEF);
        S = 3'b101; tick(); check("neg_lui",  32'hBEEF_0000);
        S = 3'b110; tick(); check("neg_zext", 32'h0000_BEEF);
        imm16 = 16'h6C44;

        S = 3'b000; tick(); check("lat_pb", 32'h2235_4678);
        @(negedge clk);
        S = 3'b011;
        #1 check("lat_no_comb", 32'h2235_4678);
        tick();
        check("lat_pc", 32'hFEDC_BA98);

        S = 3'b010; tick(); check("en_capture", 32'h7EDC_BA89);
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            S  = 3'(i + 3);
            LO = 32'h1111_0000 + 32'(i);
            tick();
            check($sformatf("en_hold%0d", i), 32'h7EDC_BA89);
        end
        S  = 3'b010;
        LO = 32'h1234_5678;
        en = 1'b1;
        tick();
        check("en_resume", 32'h1234_5678);
        LO = 32'h7EDC_BA89;

        S = 3'b011; tick(); check("mid_pre", 32'hFEDC_BA98);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1 check("mid_async", 32'h0);
        tick();
        check("mid_hold", 32'h0);
        rst_n = 1'b1;
        en    = 1'b0;
        #1 check("mid_release", 32'h0);
        tick();
        check("mid_no_en", 32'h0);
        en = 1'b1;
        tick();
        check("mid_capture", 32'hFEDC_BA98);

        S = 3'b111; tick(); check("zero_sel", 32'h0);
        tick();
        running = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
